// File: rtl/order_loader_pkg.sv
// Shared constants, order-entry field indices and FSM encoding for the conv order table.
package conv_order_pkg;

  localparam int DATA_W          = 32;
  localparam int WORDS_PER_ORDER = 32;
  localparam int ORDER_DEPTH     = 128;
  localparam int ADDR_W          = 7;
  localparam int ENTRY_W         = DATA_W * WORDS_PER_ORDER;
  localparam int WCNT_W          = $clog2(WORDS_PER_ORDER);

  // Entry count is 8 bits wide so that a completely full table is expressible.
  localparam logic [7:0] ORDER_DEPTH_N = 8'(ORDER_DEPTH);

  localparam int ORDER_F_ORDER                    = 0;
  localparam int ORDER_F_FEATURE_INPUT_BASE_ADDR  = 1;
  localparam int ORDER_F_FEATURE_INPUT_PATCH_NUM  = 2;
  localparam int ORDER_F_FEATURE_OUTPUT_PATCH_NUM = 3;
  localparam int ORDER_F_FEATURE_DOUBLE_PATCH     = 4;
  localparam int ORDER_F_FEATURE_PATCH_NUM        = 5;
  localparam int ORDER_F_ROW_SIZE                 = 6;
  localparam int ORDER_F_COL_SIZE                 = 7;
  localparam int ORDER_F_WEIGHT_QUANT_SIZE        = 8;
  localparam int ORDER_F_FEA_IN_QUANT_SIZE        = 9;
  localparam int ORDER_F_FEA_OUT_QUANT_SIZE       = 10;
  localparam int ORDER_F_STRIDE                   = 11;
  localparam int ORDER_F_RETURN_ADDR              = 12;
  localparam int ORDER_F_RETURN_PATCH_NUM         = 13;
  localparam int ORDER_F_PADDING_SIZE             = 14;
  localparam int ORDER_F_WEIGHT_DATA_LENGTH       = 15;
  localparam int ORDER_F_ACTIVATE                 = 16;
  localparam int ORDER_F_ID                       = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/order_loader_if.sv
// Word stream in, order-table write port out. The loader uses the slave side,
// the host/DMA path and the table use the master side.
interface order_loader_if;
  import conv_order_pkg::*;

  logic [DATA_W-1:0]  s_data;
  logic               s_valid;
  logic               s_ready;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ENTRY_W-1:0] wr_data;

  modport master (
    output s_data, s_valid,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/order_loader_word_assembler.sv
// Collects stream words into the slots of one order entry; entry_nxt already includes
// the word being loaded this cycle so the parent can capture a finished entry with no extra cycle.
module order_word_assembler
  import conv_order_pkg::*;
(
  input  logic               system_clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [DATA_W-1:0]  word,
  output logic               last,
  output logic [ENTRY_W-1:0] entry_nxt
);

  logic [WORDS_PER_ORDER-1:0][DATA_W-1:0] slots;
  logic [WORDS_PER_ORDER-1:0][DATA_W-1:0] slots_nxt;
  logic [WCNT_W-1:0]                      word_cnt;

  always_comb begin
    slots_nxt           = slots;
    slots_nxt[word_cnt] = word;
  end

  assign entry_nxt = slots_nxt;
  assign last      = (word_cnt == WCNT_W'(WORDS_PER_ORDER - 1));

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      slots    <= '0;
      word_cnt <= '0;
    end else if (clear) begin
      word_cnt <= '0;
    end else if (load) begin
      slots    <= slots_nxt;
      word_cnt <= last ? '0 : word_cnt + WCNT_W'(1);
    end
  end

endmodule

// File: rtl/order_loader.sv
// Packs WORDS_PER_ORDER stream words per order entry and writes entries to addresses 0..n-1;
// wr_en one cycle after an entry's last word, done pulse one cycle later; s_ready only in LOAD.
module order_loader
  import conv_order_pkg::*;
(
  input  logic                 system_clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic [7:0]           load_entry_num,
  input  logic                 load_abort,
  order_loader_if.slave        bus,
  output logic                 busy,
  output logic                 load_done,
  output logic                 task_start,
  output logic                 load_error
);

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         entry_num;
  logic [7:0]         entry_cnt;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [ENTRY_W-1:0] wr_data_q;
  logic [ENTRY_W-1:0] entry_nxt;
  logic               load_error_q;
  logic               asm_load;
  logic               asm_clear;
  logic               asm_last;
  logic               start_ok;
  logic               start_err;
  logic               entry_last;

  assign entry_last = (({1'b0, entry_cnt} + 9'd1) == {1'b0, entry_num});

  always_comb begin
    state_nxt = state;
    asm_load  = 1'b0;
    asm_clear = 1'b0;
    start_ok  = 1'b0;
    start_err = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          if (load_entry_num == 8'd0) begin
            state_nxt = DONE;
          end else if (load_entry_num > ORDER_DEPTH_N) begin
            start_err = 1'b1;
          end else begin
            state_nxt = LOAD;
            start_ok  = 1'b1;
            asm_clear = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.s_valid) begin
          asm_load = 1'b1;
          if (asm_last) begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE:   state_nxt = entry_last ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides everything decided above, including a same-cycle handshake.
    if (load_abort) begin
      state_nxt = IDLE;
      asm_load  = 1'b0;
      asm_clear = 1'b1;
      start_ok  = 1'b0;
      start_err = 1'b0;
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      entry_num    <= '0;
      entry_cnt    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      load_error_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      load_error_q <= start_err;
      if (load_abort) begin
        entry_cnt <= '0;
      end else if (start_ok) begin
        entry_num <= load_entry_num;
        entry_cnt <= '0;
      end else if (state == WRITE) begin
        entry_cnt <= entry_cnt + 8'd1;
      end
      // Capture on the edge that enters WRITE so the write appears the very next cycle.
      if (state_nxt == WRITE) begin
        wr_addr_q <= entry_cnt[ADDR_W-1:0];
        wr_data_q <= entry_nxt;
      end
    end
  end

  order_word_assembler u_asm (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .clear      (asm_clear),
    .load       (asm_load),
    .word       (bus.s_data),
    .last       (asm_last),
    .entry_nxt  (entry_nxt)
  );

  assign bus.s_ready = (state == LOAD);
  assign bus.wr_en   = (state == WRITE);
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy        = (state != IDLE);
  assign load_done   = (state == DONE);
  assign task_start  = (state == DONE);
  assign load_error  = load_error_q;

endmodule

// File: tb/tb_order_loader.sv
// Bench for order_loader: transaction-level model of accepted words, expected writes and pulses,
// checked every cycle, plus directed scenarios with literal expectations on addresses, data and timing.
module tb_order_loader;

  logic        system_clk;
  logic        rst_n;
  logic        load_start;
  logic [7:0]  load_entry_num;
  logic        load_abort;
  logic        busy;
  logic        load_done;
  logic        task_start;
  logic        load_error;

  order_loader_if bus ();

  order_loader dut (
    .system_clk     (system_clk),
    .rst_n          (rst_n),
    .load_start     (load_start),
    .load_entry_num (load_entry_num),
    .load_abort     (load_abort),
    .bus            (bus),
    .busy           (busy),
    .load_done      (load_done),
    .task_start     (task_start),
    .load_error     (load_error)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Observation log, written only by the compare process.
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, rdy_wr_cnt = 0;
  int last_wr_cyc = -1, last_hs_cyc = -1, last_done_cyc = -1, last_err_cyc = -1;
  int last_wr_addr = -1;
  logic [1023:0] tb_mem [0:127];

  // Model state: words collected for the current entry, entries written, pending pulses.
  logic          m_active, m_wen, m_done, m_err;
  logic [7:0]    m_n, m_entries;
  logic [6:0]    m_addr;
  logic [1023:0] m_data;
  logic [31:0]   m_words [$];

  initial begin
    system_clk = 1'b0;
    forever #5 system_clk = ~system_clk;
  end

  initial forever begin
    @(posedge system_clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_entry(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int idx;
    checks++;
    if (act !== exp) begin
      errors++;
      idx = 0;
      for (int i = 31; i >= 0; i--) if (act[32*i+:32] !== exp[32*i+:32]) idx = i;
      $display("FAIL %s word%0d got=%h want=%h (cycle %0d)", name, idx, act[32*idx+:32],
               exp[32*idx+:32], cyc);
    end
  endtask

  function automatic logic [1023:0] pack_words();
    logic [1023:0] e = '0;
    for (int i = 0; i < 32; i++) e[32*i+:32] = m_words[i];
    return e;
  endfunction

  // Compare process: check this cycle against the model, then advance the model on this cycle's inputs.
  initial forever begin
    @(negedge system_clk);
    if (!rst_n) begin
      chk("reset_outputs", {bus.s_ready, bus.wr_en, busy, load_done, task_start, load_error}, 0);
      chk("reset_wr_addr", bus.wr_addr, 0);
      chk_entry("reset_wr_data", bus.wr_data, '0);
      m_active = 0; m_wen = 0; m_done = 0; m_err = 0;
      m_n = 0; m_entries = 0; m_addr = 0; m_data = '0;
      m_words.delete();
    end else begin
      logic nwen, ndone, nerr;
      chk("s_ready", bus.s_ready, m_active && !m_wen);
      chk("wr_en", bus.wr_en, m_wen);
      chk("wr_addr", bus.wr_addr, m_addr);
      chk_entry("wr_data", bus.wr_data, m_data);
      chk("busy", busy, m_active || m_done);
      chk("load_done", load_done, m_done);
      chk("task_start", task_start, m_done);
      chk("load_error", load_error, m_err);

      if (bus.wr_en) begin
        wr_cnt++; last_wr_cyc = cyc; last_wr_addr = int'(bus.wr_addr);
        tb_mem[bus.wr_addr] = bus.wr_data;
      end
      if (bus.s_valid && bus.s_ready) last_hs_cyc = cyc;
      if (load_done) begin done_cnt++; last_done_cyc = cyc; end
      if (load_error) begin err_cnt++; last_err_cyc = cyc; end
      if (busy) busy_cnt++;
      if (bus.wr_en && bus.s_ready) rdy_wr_cnt++;

      nwen = 0; ndone = 0; nerr = 0;
      if (load_abort) begin
        m_active = 0; m_entries = 0; m_words.delete();
      end else if (m_done) begin
        // pulse cycle; back to idle afterwards
      end else if (!m_active) begin
        if (load_start) begin
          if (load_entry_num == 8'd0) ndone = 1;
          else if (load_entry_num > 8'd128) nerr = 1;
          else begin
            m_active = 1; m_n = load_entry_num; m_entries = 0; m_words.delete();
          end
        end
      end else if (m_wen) begin
        m_entries = m_entries + 8'd1;
        if (m_entries == m_n) begin m_active = 0; ndone = 1; end
      end else if (bus.s_valid) begin
        m_words.push_back(bus.s_data);
        if (m_words.size() == 32) begin
          nwen = 1; m_addr = m_entries[6:0]; m_data = pack_words(); m_words.delete();
        end
      end
      m_wen = nwen; m_done = ndone; m_err = nerr;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge system_clk);
    #1;
  endtask

  int start_cyc;

  task automatic start_load(input logic [7:0] n);
    load_entry_num = n;
    load_start     = 1'b1;
    start_cyc      = cyc;
    tick(1);
    load_start     = 1'b0;
  endtask

  task automatic stream(input int nwords, input logic [31:0] base, input bit gaps);
    int sent  = 0;
    int spent = 0;
    logic acc;
    while (sent < nwords && spent < 6000) begin
      bus.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data  = base + 32'(sent);
      @(negedge system_clk);
      acc = bus.s_valid && bus.s_ready;
      tick(1);
      if (acc) sent++;
      spent++;
    end
    bus.s_valid = 1'b0;
    chk("stream_words_accepted", 64'(sent), 64'(nwords));
  endtask

  int w0, d0, e0, b0;

  task automatic snap();
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
  endtask

  initial begin
    rst_n          = 1'b0;
    load_start     = 1'b0;
    load_entry_num = 8'd0;
    load_abort     = 1'b0;
    bus.s_valid    = 1'b0;
    bus.s_data     = 32'd0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("idle_busy", busy, 0);
    chk("idle_s_ready", bus.s_ready, 0);

    // 1: single entry, back-to-back words
    snap();
    start_load(8'd1);
    stream(32, 32'h100, 1'b0);
    tick(4);
    chk("t1_writes", 64'(wr_cnt - w0), 1);
    chk("t1_addr", 64'(last_wr_addr), 0);
    chk("t1_word0", tb_mem[0][31:0], 32'h100);
    chk("t1_word17", tb_mem[0][32*17+:32], 32'h111);
    chk("t1_word31", tb_mem[0][1023:992], 32'h11F);
    chk("t1_wr_latency", 64'(last_wr_cyc - last_hs_cyc), 1);
    chk("t1_done_latency", 64'(last_done_cyc - last_hs_cyc), 2);
    chk("t1_done_count", 64'(done_cnt - d0), 1);

    // 2: three entries with a gappy stream
    snap();
    start_load(8'd3);
    stream(96, 32'h200, 1'b1);
    tick(4);
    chk("t2_writes", 64'(wr_cnt - w0), 3);
    chk("t2_last_addr", 64'(last_wr_addr), 2);
    chk("t2_e1_word0", tb_mem[1][31:0], 32'h220);
    chk("t2_e2_word31", tb_mem[2][1023:992], 32'h25F);
    chk("t2_ready_in_write", 64'(rdy_wr_cnt), 0);
    chk("t2_done_count", 64'(done_cnt - d0), 1);

    // 3: zero entries, then an oversize request
    snap();
    start_load(8'd0);
    tick(3);
    chk("t3_zero_writes", 64'(wr_cnt - w0), 0);
    chk("t3_zero_done", 64'(done_cnt - d0), 1);
    chk("t3_zero_done_cycle", 64'(last_done_cyc - start_cyc), 1);
    snap();
    start_load(8'd129);
    tick(3);
    chk("t3_err_count", 64'(err_cnt - e0), 1);
    chk("t3_err_cycle", 64'(last_err_cyc - start_cyc), 1);
    chk("t3_err_busy", 64'(busy_cnt - b0), 0);
    chk("t3_err_writes", 64'(wr_cnt - w0), 0);

    // 4: abort part-way through entry 1, colliding with a handshake
    snap();
    start_load(8'd2);
    stream(40, 32'h300, 1'b0);
    load_abort  = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEAD_BEEF;
    tick(1);
    load_abort  = 1'b0;
    bus.s_valid = 1'b0;
    tick(3);
    chk("t4_abort_idle", busy, 0);
    chk("t4_abort_writes", 64'(wr_cnt - w0), 1);
    chk("t4_abort_no_done", 64'(done_cnt - d0), 0);
    start_load(8'd1);
    stream(32, 32'h400, 1'b0);
    tick(4);
    chk("t4_reload_addr", 64'(last_wr_addr), 0);
    chk("t4_reload_word0", tb_mem[0][31:0], 32'h400);

    // 5: load_start while busy is ignored
    snap();
    start_load(8'd2);
    stream(10, 32'h500, 1'b0);
    start_load(8'd5);
    stream(54, 32'h50A, 1'b0);
    tick(4);
    chk("t5_writes", 64'(wr_cnt - w0), 2);
    chk("t5_last_addr", 64'(last_wr_addr), 1);
    chk("t5_e1_word31", tb_mem[1][1023:992], 32'h53F);
    chk("t5_done_count", 64'(done_cnt - d0), 1);

    // 6: full table, then reset in the middle of a load
    snap();
    start_load(8'd128);
    stream(4096, 32'h1_0000, 1'b0);
    tick(4);
    chk("t6_writes", 64'(wr_cnt - w0), 128);
    chk("t6_last_addr", 64'(last_wr_addr), 127);
    chk("t6_e127_word31", tb_mem[127][1023:992], 32'h1_0FFF);
    chk("t6_done_count", 64'(done_cnt - d0), 1);
    start_load(8'd4);
    stream(50, 32'h2_0000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wr_addr", bus.wr_addr, 0);
    chk("t6_rst_wr_data_zero", bus.wr_data == '0, 1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    start_load(8'd1);
    stream(32, 32'h3_0000, 1'b0);
    tick(4);
    chk("t6_restart_addr", 64'(last_wr_addr), 0);
    chk("t6_restart_word0", tb_mem[0][31:0], 32'h3_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
